// File: rtl/count_sequencer_pkg.sv
// Shared definitions for the run/pause/clear display counter controller.
// Holds the state encodings, the state field width and the default
// prescaler / long-press constants used by count_sequencer and its interface.
package count_seq_pkg;

  localparam int STATE_W = 2;

  localparam int DEF_WIDTH      = 3;
  localparam int DEF_DIV_SLOW   = 100;
  localparam int DEF_DIV_FAST   = 20;
  localparam int DEF_LONG_PRESS = 50;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

endpackage

// File: rtl/count_sequencer_if.sv
// Button/control inputs and display outputs of count_sequencer.
//   btn   : debounced button level, 1 = pressed
//   fast  : rate select, 1 = fast prescaler
//   dir   : 1 = count up, 0 = count down
//   count : counter value for the display
//   state : IDLE / RUN / PAUSE encoding
//   tick  : one-cycle pulse when count takes a new value
//   wrap  : one-cycle pulse with tick when count wrapped
// master drives the controls (button/switch side); slave is the sequencer.
interface count_sequencer_if
  import count_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic               btn;
  logic               fast;
  logic               dir;
  logic [WIDTH-1:0]   count;
  logic [STATE_W-1:0] state;
  logic               tick;
  logic               wrap;

  modport master (
    output btn, fast, dir,
    input  count, state, tick, wrap
  );

  modport slave (
    input  btn, fast, dir,
    output count, state, tick, wrap
  );
endinterface

// File: rtl/count_sequencer_press_classifier.sv
// Turns a debounced button level into registered short/long press pulses.
//   clk, reset : system clock, synchronous active-high reset
//   btn        : debounced button level
//   short_cmd  : one-cycle pulse on release of a press shorter than LONG_PRESS
//   long_cmd   : one-cycle pulse when a press reaches LONG_PRESS cycles
module press_classifier #(
  parameter int LONG_PRESS = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic short_cmd,
  output logic long_cmd
);

  localparam int HW = $clog2(LONG_PRESS + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS - 1);

  logic [HW-1:0] hold;
  logic          btn_q;
  // Set once btn has been seen low after reset: a press already in progress
  // at reset never starts the hold counter, so its release is silent.
  logic          seen_low;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold      <= '0;
      btn_q     <= 1'b0;
      seen_low  <= 1'b0;
      short_cmd <= 1'b0;
      long_cmd  <= 1'b0;
    end else begin
      btn_q     <= btn;
      seen_low  <= seen_low | ~btn;
      short_cmd <= 1'b0;
      long_cmd  <= 1'b0;
      if (!btn) begin
        hold <= '0;
        // hold != 0 excludes a press that was discarded at reset
        if (btn_q && hold != '0 && hold < HOLD_MAX)
          short_cmd <= 1'b1;
      end else if (seen_low && hold != HOLD_MAX) begin
        hold <= hold + 1'b1;
        if (hold == HOLD_LAST)
          long_cmd <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// Run/pause/clear controller for the display counter.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : slave side of count_sequencer_if (btn/fast/dir in,
//                count/state/tick/wrap out, all outputs registered)
// Short press toggles IDLE->RUN, RUN<->PAUSE; long press returns to IDLE and
// clears the count. In RUN a prescaler produces one count step every DIV
// cycles, DIV chosen by fast.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DIV_SLOW   = DEF_DIV_SLOW,
  parameter int DIV_FAST   = DEF_DIV_FAST,
  parameter int LONG_PRESS = DEF_LONG_PRESS
) (
  input logic              clk,
  input logic              reset,
  count_sequencer_if.slave bus
);

  localparam int PW = $clog2(DIV_SLOW);
  localparam logic [PW-1:0] SLOW_LAST = PW'(DIV_SLOW - 1);
  localparam logic [PW-1:0] FAST_LAST = PW'(DIV_FAST - 1);

  logic short_cmd;
  logic long_cmd;

  press_classifier #(
    .LONG_PRESS(LONG_PRESS)
  ) u_press (
    .clk       (clk),
    .reset     (reset),
    .btn       (bus.btn),
    .short_cmd (short_cmd),
    .long_cmd  (long_cmd)
  );

  state_t           st;
  logic [PW-1:0]    presc;
  logic [WIDTH-1:0] cnt;
  logic             tick_q;
  logic             wrap_q;
  logic [PW-1:0]    presc_last;
  logic             due;

  // >= rather than == so a slow->fast switch with the prescaler already
  // past the fast terminal value ticks on the next cycle instead of rolling over.
  always_comb begin
    presc_last = bus.fast ? FAST_LAST : SLOW_LAST;
    due        = (presc >= presc_last);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st     <= ST_IDLE;
      presc  <= '0;
      cnt    <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      if (long_cmd) begin
        st    <= ST_IDLE;
        cnt   <= '0;
        presc <= '0;
      end else begin
        case (st)
          ST_IDLE: begin
            presc <= '0;
            if (short_cmd)
              st <= ST_RUN;
          end
          ST_RUN: begin
            // A pause request wins over a due tick; prescaler stays put so
            // resuming finishes the interrupted period.
            if (short_cmd) begin
              st <= ST_PAUSE;
            end else if (due) begin
              presc  <= '0;
              tick_q <= 1'b1;
              if (bus.dir) begin
                cnt    <= cnt + 1'b1;
                wrap_q <= (cnt == '1);
              end else begin
                cnt    <= cnt - 1'b1;
                wrap_q <= (cnt == '0);
              end
            end else begin
              presc <= presc + 1'b1;
            end
          end
          ST_PAUSE: begin
            if (short_cmd)
              st <= ST_RUN;
          end
          default: st <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.count = cnt;
  assign bus.state = st;
  assign bus.tick  = tick_q;
  assign bus.wrap  = wrap_q;

endmodule
